// File: rtl/mem_viewer.sv
// ============================================================================
// Module   : mem_viewer
// Purpose  : Steps a data-memory view address from buttons or a scan timer,
//            registers the word read back and flags changes under view.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_viewer #(
  parameter int ADDR_W        = 4,
  parameter int DATA_W        = 8,
  parameter int WRAP          = 1,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int SCAN_PERIOD   = 100_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              incLevel,
  input  logic              decLevel,
  input  logic              modePulse,
  input  logic [DATA_W-1:0] memReadData,
  output logic [ADDR_W-1:0] memReadAddress,
  output logic [ADDR_W-1:0] viewAddress,
  output logic [DATA_W-1:0] viewData,
  output logic              scanMode,
  output logic              dataChanged
);

  localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_REP_W   = $clog2(c_REP_MAX) + 1;
  localparam int c_SCAN_W  = $clog2(SCAN_PERIOD) + 1;

  localparam logic [c_REP_W-1:0]  c_REP_ONE    = c_REP_W'(1);
  localparam logic [c_REP_W-1:0]  c_REP_DELAY  = c_REP_W'(REPEAT_DELAY);
  localparam logic [c_REP_W-1:0]  c_REP_PERIOD = c_REP_W'(REPEAT_PERIOD);
  localparam logic [c_SCAN_W-1:0] c_SCAN_ONE   = c_SCAN_W'(1);
  localparam logic [c_SCAN_W-1:0] c_SCAN_LAST  = c_SCAN_W'(SCAN_PERIOD - 1);
  localparam logic [ADDR_W-1:0]   c_ADDR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]   c_ADDR_MAX   = '1;

  typedef enum logic [0:0] {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_t;

  state_t              r_state, w_stateNext;
  logic                r_incPrev, r_decPrev;
  logic                r_incReady, r_decReady;
  logic                r_repActive, r_repFirst;
  logic [c_REP_W-1:0]  r_repCnt;
  logic [c_SCAN_W-1:0] r_scanCnt;
  logic [ADDR_W-1:0]   r_viewAddress;
  logic [DATA_W-1:0]   r_viewData;
  logic                r_dataChanged;
  logic                r_addrMoved;

  logic                w_incOnly, w_decOnly, w_incPress, w_decPress, w_held;
  logic                w_stepInc, w_stepDec, w_stepScan;
  logic                w_repActiveNext, w_repFirstNext;
  logic [c_REP_W-1:0]  w_repCntNext, w_repLimit;
  logic [c_SCAN_W-1:0] w_scanCntNext;
  logic [ADDR_W-1:0]   w_addrNext;
  logic                w_addrChange;

  // A press only counts once the button has been seen low since reset.
  assign w_incOnly  = incLevel & ~decLevel;
  assign w_decOnly  = decLevel & ~incLevel;
  assign w_incPress = w_incOnly & ~r_incPrev & r_incReady;
  assign w_decPress = w_decOnly & ~r_decPrev & r_decReady;
  assign w_held     = r_repActive & ((w_incOnly & r_incPrev) | (w_decOnly & r_decPrev));
  assign w_repLimit = r_repFirst ? c_REP_DELAY : c_REP_PERIOD;

  always_comb begin
    w_stateNext     = r_state;
    w_stepInc       = 1'b0;
    w_stepDec       = 1'b0;
    w_stepScan      = 1'b0;
    w_repActiveNext = 1'b0;
    w_repFirstNext  = r_repFirst;
    w_repCntNext    = '0;
    w_scanCntNext   = '0;
    case (r_state)
      MANUAL: begin
        if (modePulse) begin
          w_stateNext = SCAN;
        end else if (w_incPress || w_decPress) begin
          w_stepInc       = w_incPress;
          w_stepDec       = w_decPress;
          w_repActiveNext = 1'b1;
          w_repFirstNext  = 1'b1;
          w_repCntNext    = c_REP_ONE;
        end else if (w_held) begin
          w_repActiveNext = 1'b1;
          if (r_repCnt == w_repLimit) begin
            w_stepInc      = w_incOnly;
            w_stepDec      = w_decOnly;
            w_repFirstNext = 1'b0;
            w_repCntNext   = c_REP_ONE;
          end else begin
            w_repCntNext = r_repCnt + c_REP_ONE;
          end
        end
      end
      SCAN: begin
        if (modePulse) begin
          w_stateNext = MANUAL;
        end else if (r_scanCnt == c_SCAN_LAST) begin
          w_stepScan = 1'b1;
        end else begin
          w_scanCntNext = r_scanCnt + c_SCAN_ONE;
        end
      end
      default: w_stateNext = MANUAL;
    endcase
  end

  // Scan always wraps; manual steps saturate at the ends when WRAP is 0.
  always_comb begin
    w_addrNext = r_viewAddress;
    if (w_stepScan) begin
      w_addrNext = r_viewAddress + c_ADDR_ONE;
    end else if (w_stepInc) begin
      if (r_viewAddress != c_ADDR_MAX || WRAP != 0) w_addrNext = r_viewAddress + c_ADDR_ONE;
    end else if (w_stepDec) begin
      if (r_viewAddress != '0 || WRAP != 0) w_addrNext = r_viewAddress - c_ADDR_ONE;
    end
  end

  assign w_addrChange = (w_addrNext != r_viewAddress);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= MANUAL;
      r_incPrev     <= 1'b0;
      r_decPrev     <= 1'b0;
      r_incReady    <= 1'b0;
      r_decReady    <= 1'b0;
      r_repActive   <= 1'b0;
      r_repFirst    <= 1'b0;
      r_repCnt      <= '0;
      r_scanCnt     <= '0;
      r_viewAddress <= '0;
      r_viewData    <= '0;
      r_dataChanged <= 1'b0;
      r_addrMoved   <= 1'b1;
    end else begin
      r_state       <= w_stateNext;
      r_incPrev     <= incLevel;
      r_decPrev     <= decLevel;
      r_incReady    <= r_incReady | ~incLevel;
      r_decReady    <= r_decReady | ~decLevel;
      r_repActive   <= w_repActiveNext;
      r_repFirst    <= w_repFirstNext;
      r_repCnt      <= w_repCntNext;
      r_scanCnt     <= w_scanCntNext;
      r_viewAddress <= w_addrNext;
      r_viewData    <= memReadData;
      r_addrMoved   <= w_addrChange;
      // viewData is stale for one cycle after a move, so skip that compare.
      if (w_addrChange) r_dataChanged <= 1'b0;
      else r_dataChanged <= r_dataChanged | (~r_addrMoved & (memReadData != r_viewData));
    end
  end

  assign memReadAddress = r_viewAddress;
  assign viewAddress    = r_viewAddress;
  assign viewData       = r_viewData;
  assign scanMode       = (r_state == SCAN);
  assign dataChanged    = r_dataChanged;

endmodule

`default_nettype wire

// File: tb/tb_mem_viewer.sv
// ============================================================================
// Module   : tb_mem_viewer
// Purpose  : Self-checking bench for mem_viewer (directed table + random model).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_viewer;
  localparam int AW = 4, DW = 8, RD = 4, RP = 2, SP = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, incLevel, decLevel, modePulse;
  logic [DW-1:0] mem [16];
  logic [DW-1:0] memReadData, memReadData0, viewData, viewData0;
  logic [AW-1:0] memReadAddress, memReadAddress0, viewAddress, viewAddress0;
  logic          scanMode, scanMode0, dataChanged, dataChanged0;

  assign memReadData  = mem[memReadAddress];
  assign memReadData0 = mem[memReadAddress0];

  mem_viewer #(.ADDR_W(AW), .DATA_W(DW), .WRAP(1), .REPEAT_DELAY(RD),
               .REPEAT_PERIOD(RP), .SCAN_PERIOD(SP)) dut (
    .clk(clk), .reset(reset), .incLevel(incLevel), .decLevel(decLevel),
    .modePulse(modePulse), .memReadData(memReadData), .memReadAddress(memReadAddress),
    .viewAddress(viewAddress), .viewData(viewData), .scanMode(scanMode),
    .dataChanged(dataChanged));

  mem_viewer #(.ADDR_W(AW), .DATA_W(DW), .WRAP(0), .REPEAT_DELAY(RD),
               .REPEAT_PERIOD(RP), .SCAN_PERIOD(SP)) dut0 (
    .clk(clk), .reset(reset), .incLevel(incLevel), .decLevel(decLevel),
    .modePulse(modePulse), .memReadData(memReadData0), .memReadAddress(memReadAddress0),
    .viewAddress(viewAddress0), .viewData(viewData0), .scanMode(scanMode0),
    .dataChanged(dataChanged0));

  int nCmp = 0, nBad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input bit inc);
    if (inc) incLevel = 1'b1; else decLevel = 1'b1;
    tick();
    incLevel = 1'b0;
    decLevel = 1'b0;
    tick();
  endtask

  task automatic doReset();
    reset = 1'b1; incLevel = 1'b0; decLevel = 1'b0; modePulse = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  typedef struct {
    bit       inc;
    bit       dec;
    bit       mp;
    int       addr;
    bit       scan;
  } vec_t;
  vec_t tbl [21];

  // Reference model: time-since-press and time-since-entry rules.
  int        mAddr, holdBtn, holdT, scanT;
  bit        mScan, mDc, mMoved, mIncPrev, mDecPrev, mIncSeen, mDecSeen;
  logic [DW-1:0] mData;

  function automatic int stepAddr(input int btn, input int a);
    return (btn == 1) ? (a + 1) % 16 : (a + 15) % 16;
  endfunction

  task automatic modelEdge(input bit rst, input bit inc, input bit dec, input bit mp,
                           input logic [DW-1:0] mv);
    int newAddr, btn;
    bit prevB, seenB;
    if (rst) begin
      mAddr = 0; mScan = 0; mData = '0; mDc = 0; holdBtn = 0; holdT = 0; scanT = 0;
      mMoved = 1; mIncPrev = 0; mDecPrev = 0; mIncSeen = 0; mDecSeen = 0;
      return;
    end
    newAddr = mAddr;
    btn   = (inc && !dec) ? 1 : ((dec && !inc) ? 2 : 0);
    prevB = (btn == 1) ? mIncPrev : mDecPrev;
    seenB = (btn == 1) ? mIncSeen : mDecSeen;
    if (mp) begin
      mScan = !mScan; scanT = 0; holdBtn = 0;
    end else if (mScan) begin
      scanT++; holdBtn = 0;
      if (scanT % SP == 0) newAddr = (mAddr + 1) % 16;
    end else if (btn != 0 && !prevB && seenB) begin
      holdBtn = btn; holdT = 0; newAddr = stepAddr(btn, mAddr);
    end else if (btn != 0 && btn == holdBtn) begin
      holdT++;
      if (holdT == RD || (holdT > RD && (holdT - RD) % RP == 0)) newAddr = stepAddr(btn, mAddr);
    end else begin
      holdBtn = 0;
    end
    if (newAddr != mAddr) mDc = 0;
    else if (!mMoved && mv != mData) mDc = 1;
    mMoved = (newAddr != mAddr);
    mData  = mv;
    mAddr  = newAddr;
    mIncPrev = inc; mDecPrev = dec;
    mIncSeen = mIncSeen | !inc; mDecSeen = mDecSeen | !dec;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = DW'(i * 17 + 1);
    mem[5] = 8'h3C;

    // Reset state
    doReset();
    reset = 1'b1; tick();
    chk("rst_addr", 32'(viewAddress), 0);
    chk("rst_data", 32'(viewData), 0);
    chk("rst_scan", 32'(scanMode), 0);
    chk("rst_dc", 32'(dataChanged), 0);
    reset = 1'b0; tick();

    // Single press and read latency
    incLevel = 1'b1; tick();
    chk("press_addr", 32'(viewAddress), 1);
    chk("press_rdaddr", 32'(memReadAddress), 1);
    incLevel = 1'b0; tick();
    chk("press_data", 32'(viewData), 32'(mem[1]));

    // Hold/repeat, both buttons, release, coincident modePulse, short scan
    tbl[0]  = '{1,0,0,1,0};  tbl[1]  = '{1,0,0,1,0};  tbl[2]  = '{1,0,0,1,0};
    tbl[3]  = '{1,0,0,1,0};  tbl[4]  = '{1,0,0,2,0};  tbl[5]  = '{1,0,0,2,0};
    tbl[6]  = '{1,0,0,3,0};  tbl[7]  = '{1,0,0,3,0};  tbl[8]  = '{1,0,0,4,0};
    tbl[9]  = '{1,0,0,4,0};  tbl[10] = '{1,1,0,4,0};  tbl[11] = '{1,1,0,4,0};
    tbl[12] = '{0,0,0,4,0};  tbl[13] = '{0,1,0,3,0};  tbl[14] = '{0,0,0,3,0};
    tbl[15] = '{1,0,1,3,1};  tbl[16] = '{0,0,0,3,1};  tbl[17] = '{0,0,0,3,1};
    tbl[18] = '{0,0,0,4,1};  tbl[19] = '{0,0,1,4,0};  tbl[20] = '{0,0,0,4,0};
    doReset();
    for (int i = 0; i < 21; i++) begin
      incLevel = tbl[i].inc; decLevel = tbl[i].dec; modePulse = tbl[i].mp;
      tick();
      chk($sformatf("tbl%0d_addr", i), 32'(viewAddress), 32'(tbl[i].addr));
      chk($sformatf("tbl%0d_scan", i), 32'(scanMode), 32'(tbl[i].scan));
    end
    incLevel = 0; decLevel = 0; modePulse = 0;

    // Wrap vs saturate at both ends
    doReset();
    decLevel = 1'b1; tick();
    chk("wrap1_dec0", 32'(viewAddress), 15);
    chk("wrap0_dec0", 32'(viewAddress0), 0);
    decLevel = 1'b0; tick();
    for (int i = 0; i < 15; i++) press(1'b1);
    chk("wrap0_at15", 32'(viewAddress0), 15);
    chk("wrap1_at14", 32'(viewAddress), 14);
    incLevel = 1'b1; tick();
    chk("wrap0_inc15", 32'(viewAddress0), 15);
    incLevel = 1'b0; tick();
    incLevel = 1'b1; tick();
    chk("wrap1_inc15", 32'(viewAddress), 0);
    incLevel = 1'b0; tick();

    // Scan from 14 with ignored button pulses
    doReset();
    press(1'b0); press(1'b0);
    modePulse = 1'b1; tick(); modePulse = 1'b0;
    chk("scan_enter", 32'(scanMode), 1);
    chk("scan_addr0", 32'(viewAddress), 14);
    for (int c = 1; c <= 9; c++) begin
      incLevel = c[0];
      tick();
      chk($sformatf("scan_c%0d", c), 32'(viewAddress), (c < 3) ? 14 : (c < 6) ? 15 : (c < 9) ? 0 : 1);
    end
    incLevel = 1'b0;
    modePulse = 1'b1; tick(); modePulse = 1'b0;
    chk("scan_leave_mode", 32'(scanMode), 0);
    chk("scan_leave_addr", 32'(viewAddress), 1);

    // dataChanged set, sticky, cleared by step
    doReset();
    for (int i = 0; i < 5; i++) press(1'b1);
    tick();
    chk("dc_data5", 32'(viewData), 32'h3C);
    chk("dc_idle", 32'(dataChanged), 0);
    mem[5] = 8'hA1; tick();
    chk("dc_set", 32'(dataChanged), 1);
    tick();
    chk("dc_sticky", 32'(dataChanged), 1);
    chk("dc_newdata", 32'(viewData), 32'hA1);
    incLevel = 1'b1; tick();
    chk("dc_step_addr", 32'(viewAddress), 6);
    chk("dc_clear", 32'(dataChanged), 0);
    incLevel = 1'b0; tick();
    mem[5] = 8'h3C;

    // Reset mid-scan with button held
    doReset();
    modePulse = 1'b1; tick(); modePulse = 1'b0;
    incLevel = 1'b1;
    repeat (4) tick();
    reset = 1'b1; tick();
    chk("rscan_addr", 32'(viewAddress), 0);
    chk("rscan_data", 32'(viewData), 0);
    chk("rscan_mode", 32'(scanMode), 0);
    chk("rscan_dc", 32'(dataChanged), 0);
    reset = 1'b0;
    repeat (6) tick();
    chk("rheld_addr", 32'(viewAddress), 0);
    chk("rheld_mode", 32'(scanMode), 0);
    incLevel = 1'b0; tick();
    incLevel = 1'b1; tick();
    chk("rrepress_addr", 32'(viewAddress), 1);
    incLevel = 1'b0; tick();

    // Randomised run against the reference model
    reset = 1'b1; incLevel = 0; decLevel = 0; modePulse = 0;
    modelEdge(1'b1, 1'b0, 1'b0, 1'b0, '0);
    tick();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(7) == 0) incLevel = ~incLevel;
      if ($urandom_range(7) == 0) decLevel = ~decLevel;
      modePulse = ($urandom_range(39) == 0);
      reset     = ($urandom_range(249) == 0);
      if ($urandom_range(9) == 0) mem[$urandom_range(15)] = DW'($urandom);
      if ($urandom_range(19) == 0) mem[mAddr] = DW'($urandom);
      modelEdge(reset, incLevel, decLevel, modePulse, mem[mAddr]);
      tick();
      chk("rnd_addr", 32'(viewAddress), 32'(mAddr));
      chk("rnd_rdaddr", 32'(memReadAddress), 32'(mAddr));
      chk("rnd_data", 32'(viewData), 32'(mData));
      chk("rnd_scan", 32'(scanMode), 32'(mScan));
      chk("rnd_dc", 32'(dataChanged), 32'(mDc));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/mem_viewer.md
MEM_VIEWER -- requirements
Module: mem_viewer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, data-memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, data-memory word width.
REQ-003 The block SHALL have parameter WRAP, default 1: 1 = address wraps at ends, 0 = address saturates at ends (manual mode only).
REQ-004 The block SHALL have parameter REPEAT_DELAY, default 50_000_000, cycles from the initial step to the first auto-repeat step.
REQ-005 The block SHALL have parameter REPEAT_PERIOD, default 10_000_000, cycles between subsequent auto-repeat steps.
REQ-006 The block SHALL have parameter SCAN_PERIOD, default 100_000_000, cycles per address step in scan mode.
REQ-007 clk  input  1  single system clock; all state updates on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 incLevel  input  1  debounced level of the increment button.
REQ-010 decLevel  input  1  debounced level of the decrement button.
REQ-011 modePulse  input  1  one-cycle pulse that toggles manual/scan mode.
REQ-012 memReadData  input  DATA_W  data returned by data memory for memReadAddress (combinational read).
REQ-013 memReadAddress  output  ADDR_W  read address to data memory; equals viewAddress combinationally.
REQ-014 viewAddress  output  ADDR_W  registered address being displayed.
REQ-015 viewData  output  DATA_W  registered copy of memReadData.
REQ-016 scanMode  output  1  1 while in SCAN state.
REQ-017 dataChanged  output  1  sticky flag: word at the displayed address changed while being viewed.

Function
REQ-018 The block SHALL implement a two-state FSM, MANUAL and SCAN; modePulse toggles the state at the next rising edge.
REQ-019 In MANUAL, a step SHALL occur at the edge where exactly one of incLevel/decLevel is 1 and was 0 the previous cycle (internal edge-detect registers); viewAddress changes at that edge.
REQ-020 While the same single button stays held, a repeat step SHALL occur REPEAT_DELAY cycles after the initial step, then every REPEAT_PERIOD cycles.
REQ-021 Releasing the held button, or both levels being 1, SHALL clear the repeat counter and produce no step.
REQ-022 Increment at all-ones SHALL give 0 when WRAP=1 and hold all-ones when WRAP=0; decrement at 0 SHALL give all-ones when WRAP=1 and hold 0 when WRAP=0.
REQ-023 In SCAN, incLevel/decLevel SHALL be ignored and the repeat counter held at 0; viewAddress SHALL increment every SCAN_PERIOD cycles, always wrapping regardless of WRAP.
REQ-024 Entering SCAN SHALL clear the scan counter, so the first scan step occurs SCAN_PERIOD cycles after entry; leaving SCAN SHALL keep viewAddress.
REQ-025 modePulse coincident with a step condition SHALL toggle the mode and discard the step.
REQ-026 viewData SHALL register memReadData every cycle (one-cycle latency after viewAddress changes).
REQ-027 dataChanged SHALL set when viewAddress is unchanged over the previous cycle and memReadData differs from viewData, SHALL stay set until viewAddress changes, and SHALL clear in the cycle viewAddress changes.
REQ-028 Counters SHALL be sized as $clog2 of their maximum parameter plus 1 and SHALL not overflow.

Reset
REQ-029 reset SHALL give viewAddress=0, viewData=0, scanMode=0 (MANUAL), dataChanged=0, all counters 0, edge-detect registers 0; reset has priority over every other input.
REQ-030 A button held through reset deassertion SHALL not step until released and pressed again.
REQ-031 reset asserted mid-scan or mid-repeat SHALL abort the activity and resume in MANUAL at address 0.

Verification (ADDR_W=4, DATA_W=8, REPEAT_DELAY=4, REPEAT_PERIOD=2, SCAN_PERIOD=3)
REQ-032 Press incLevel for 1 cycle from address 0 -> viewAddress=1 next cycle; viewData=mem[1] one cycle later.
REQ-033 Hold incLevel 10 cycles from 0 -> steps at cycles 0, 4, 6, 8; viewAddress=4; both buttons held -> no change.
REQ-034 WRAP=1: dec at 0 -> 15; inc at 15 -> 0. WRAP=0: dec at 0 -> 0; inc at 15 -> 15.
REQ-035 modePulse, then 9 idle cycles from address 14 -> scanMode=1, addresses 15, 0, 1 at cycles 3, 6, 9; incLevel pulses ignored.
REQ-036 At fixed address 5, change mem[5] from 0x3C to 0xA1 -> dataChanged=1 next cycle, stays 1; inc step -> dataChanged=0.
REQ-037 reset during scan with incLevel held -> all outputs 0, MANUAL, no step until incLevel falls and rises again.
